// File: rtl/avg_pool_sequencer_if.sv
// avg_pool_if
//   Pixel streams around the 2x2 average-pool sequencer.
//   Input stream  : in_valid / in_ready / in_pixel            (raster order)
//   Output stream : out_valid / out_ready / out_pixel / out_last
//   Modports      : slave  = sequencer side
//                   master = pixel producer / classifier buffer side
interface avg_pool_if #(
   parameter int RESOLUTION = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [RESOLUTION-1:0] in_pixel;
   logic                  out_valid;
   logic                  out_ready;
   logic [RESOLUTION-1:0] out_pixel;
   logic                  out_last;

   modport slave (
      input  in_valid, in_pixel, out_ready,
      output in_ready, out_valid, out_pixel, out_last
   );

   modport master (
      output in_valid, in_pixel, out_ready,
      input  in_ready, out_valid, out_pixel, out_last
   );
endinterface

// File: rtl/avg_pool_sequencer.sv
// avg_pool_sequencer
//   Frame-level sequencer for 2x2 average pooling of one IMG_W x IMG_H image.
//   Even rows are stored in a line buffer; on each odd-row odd-column pixel the
//   2x2 window is summed and its average is registered onto the output stream.
//
// Ports
//   clk    in   single clock, rising edge
//   reset  in   synchronous, active-high
//   start  in   one-cycle frame request, honoured only in IDLE
//   busy   out  high whenever the sequencer is not IDLE
//   done   out  one-cycle pulse after the final output has been accepted
//   pix    avg_pool_if.slave: input pixel stream and averaged output stream
//
// Build option
//   POOL_ROUND_EN  defined  : out_pixel = (sum + 2) >> 2  (round half up)
//                  undefined: out_pixel = sum >> 2        (truncate)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for start, input not accepted
// LOAD_EVEN  | storing an even row into line_buf
// LOAD_ODD   | odd row: even col -> left_reg, odd col -> window result
// DRAIN      | all pixels consumed, waiting for final output acceptance
// DONE       | done pulse, back to IDLE
module avg_pool_sequencer #(
   parameter int RESOLUTION = 8,
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      start,
   output logic      busy,
   output logic      done,
   avg_pool_if.slave pix
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int SW = RESOLUTION + 2;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);

   if ((IMG_W % 2) != 0) begin : g_bad_width
      $error("avg_pool_sequencer: IMG_W must be even");
   end
   if ((IMG_H % 2) != 0) begin : g_bad_height
      $error("avg_pool_sequencer: IMG_H must be even");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_EVEN,
      S_LOAD_ODD,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;

   logic [RESOLUTION-1:0] line_buf [IMG_W];
   logic [RESOLUTION-1:0] left_reg;

   logic                  out_valid_q;
   logic [RESOLUTION-1:0] out_pixel_q;
   logic                  out_last_q;

   logic                  in_ready;
   logic                  in_acc;
   logic                  odd_col;
   logic                  win_load;
   logic                  win_last;
   logic [CW-1:0]         col_pair;
   logic [SW-1:0]         sum;
   logic [RESOLUTION-1:0] avg;

   assign odd_col  = col_q[0];
   // Left column of the current window in the line buffer.
   assign col_pair = col_q & ~COL_ONE;
   assign in_acc   = pix.in_valid & in_ready;
   assign win_load = in_acc & (state_q == S_LOAD_ODD) & odd_col;
   assign win_last = (row_q == ROW_LAST) && (col_q == COL_LAST);

   // Two extra bits hold the sum of four full-scale pixels without overflow.
   assign sum = SW'(line_buf[col_pair]) + SW'(line_buf[col_q])
              + SW'(left_reg) + SW'(pix.in_pixel);

`ifdef POOL_ROUND_EN
   logic [SW-1:0] sum_rnd;
   // Max 1020 + 2 still fits SW bits, and (1022 >> 2) = 255.
   assign sum_rnd = sum + SW'(2);
   assign avg     = RESOLUTION'(sum_rnd >> 2);
`else
   assign avg     = RESOLUTION'(sum >> 2);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      in_ready = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD_EVEN;
               col_d   = '0;
               row_d   = '0;
            end
         end

         S_LOAD_EVEN: begin
            in_ready = 1'b1;
            if (in_acc) begin
               if (col_q == COL_LAST) begin
                  col_d   = '0;
                  row_d   = row_q + RW'(1);
                  state_d = S_LOAD_ODD;
               end else begin
                  col_d = col_q + COL_ONE;
               end
            end
         end

         S_LOAD_ODD: begin
            // Odd columns produce a result, so they wait for room in the
            // output register; accept and replace in the same cycle is allowed.
            in_ready = odd_col ? (!out_valid_q || pix.out_ready) : 1'b1;
            if (in_acc) begin
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (row_q == ROW_LAST) begin
                     row_d   = '0;
                     state_d = S_DRAIN;
                  end else begin
                     row_d   = row_q + RW'(1);
                     state_d = S_LOAD_EVEN;
                  end
               end else begin
                  col_d = col_q + COL_ONE;
               end
            end
         end

         S_DRAIN: begin
            if (!out_valid_q || pix.out_ready) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Pixel storage is never cleared; every entry is rewritten before use.
   always_ff @(posedge clk) begin
      if ((state_q == S_LOAD_EVEN) && in_acc) begin
         line_buf[col_q] <= pix.in_pixel;
      end
      if ((state_q == S_LOAD_ODD) && in_acc && !odd_col) begin
         left_reg <= pix.in_pixel;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_pixel_q <= '0;
         out_last_q  <= 1'b0;
      end else if (win_load) begin
         out_valid_q <= 1'b1;
         out_pixel_q <= avg;
         out_last_q  <= win_last;
      end else if (out_valid_q && pix.out_ready) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end
   end

   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign pix.in_ready  = in_ready;
   assign pix.out_valid = out_valid_q;
   assign pix.out_pixel = out_pixel_q;
   assign pix.out_last  = out_last_q;

endmodule
